// File: rtl/mem_arb_pkg.sv
// Shared types and derived widths for the main-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_t;

  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_BURST_LEN  = 4;

  // Widths for the default configuration
  localparam int unsigned BEAT_W   = $clog2(DEF_BURST_LEN);
  localparam int unsigned OFFSET_W = $clog2(DEF_BURST_LEN * DEF_DATA_WIDTH / 8);

  // Beat-counter width for an arbitrary line length
  function automatic int unsigned beat_w_of(input int unsigned burst_len);
    return $clog2(burst_len);
  endfunction

  // Number of byte-offset bits inside one cache line
  function automatic int unsigned offset_w_of(input int unsigned burst_len,
                                              input int unsigned data_width);
    return $clog2(burst_len * data_width / 8);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker between the icache and dcache requesters.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  req_t last_served,
  output logic grant_valid,
  output req_t grant
);

  // On a tie the requester that was not served last wins
  always_comb begin
    grant_valid = i_req | d_req;
    grant       = REQ_I;
    if (i_req && d_req) begin
      grant = (last_served == REQ_I) ? REQ_D : REQ_I;
    end else if (d_req) begin
      grant = REQ_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the main-memory port between icache refills and dcache
// refill/writeback bursts, one whole-line burst at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned BURST_LEN  = DEF_BURST_LEN
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_req,
  input  logic [ADDR_WIDTH-1:0]        i_addr,
  output logic [DATA_WIDTH-1:0]        i_rdata,
  output logic                         i_rvalid,
  output logic                         i_done,
  input  logic                         d_req,
  input  logic                         d_we,
  input  logic [ADDR_WIDTH-1:0]        d_addr,
  input  logic [DATA_WIDTH-1:0]        d_wdata,
  output logic [$clog2(BURST_LEN)-1:0] d_beat,
  output logic [DATA_WIDTH-1:0]        d_rdata,
  output logic                         d_rvalid,
  output logic                         d_done,
  output logic                         mem_valid,
  output logic                         mem_we,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  input  logic                         mem_ready,
  input  logic [DATA_WIDTH-1:0]        mem_rdata
);

  localparam int unsigned BW         = beat_w_of(BURST_LEN);
  localparam int unsigned LINE_OFF_W = offset_w_of(BURST_LEN, DATA_WIDTH);
  localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
    ADDR_WIDTH'((64'd1 << LINE_OFF_W) - 64'd1);

  state_t                state;
  req_t                  owner;
  req_t                  last_served;
  req_t                  grant;
  logic                  grant_valid;
  logic                  we;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [BW-1:0]         beat;
  logic                  accept;
  logic                  last_beat;

  rr_pick2 u_pick (
    .i_req       (i_req),
    .d_req       (d_req),
    .last_served (last_served),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  assign sel_addr  = (grant == REQ_D) ? d_addr : i_addr;
  assign accept    = (state == BURST) && mem_ready;
  assign last_beat = (beat == BW'(BURST_LEN - 1));
  assign d_beat    = beat;

  // Burst sequencing: grant in IDLE, step beats on acceptance, one RESP cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= REQ_I;
      last_served <= REQ_I;
      we          <= 1'b0;
      base        <= '0;
      beat        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner <= grant;
            we    <= (grant == REQ_D) && d_we;
            base  <= sel_addr & ~OFF_MASK;
            beat  <= '0;
            state <= BURST;
          end
        end
        BURST: begin
          if (mem_ready) begin
            if (last_beat) begin
              beat        <= '0;
              last_served <= owner;
              state       <= RESP;
            end else begin
              beat <= beat + BW'(1);
            end
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Return accepted read beats to the owning cache one cycle later
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_rdata  <= '0;
      i_rvalid <= 1'b0;
      d_rdata  <= '0;
      d_rvalid <= 1'b0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      if (accept && !we) begin
        if (owner == REQ_I) begin
          i_rdata  <= mem_rdata;
          i_rvalid <= 1'b1;
        end else begin
          d_rdata  <= mem_rdata;
          d_rvalid <= 1'b1;
        end
      end
    end
  end

  // Memory-side beat request and completion pulses
  always_comb begin
    mem_valid = (state == BURST);
    mem_we    = mem_valid && we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_valid) begin
      mem_addr  = base + ADDR_WIDTH'(beat) * ADDR_WIDTH'(BEAT_BYTES);
      mem_wdata = d_wdata;
    end
    i_done = (state == RESP) && (owner == REQ_I);
    d_done = (state == RESP) && (owner == REQ_D);
  end

endmodule
